// File: rtl/barrel_shifter.sv
// 16-bit registered barrel shifter/rotator for the datapath shift unit.
// A four-stage log2 mux network (1, 2, 4, 8 positions) feeds one output
// register, so a result appears one cycle after its operands are sampled.
// Opcodes 5..7 are reserved and pass the operand through unchanged.
module barrel_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] i,
  input  logic [3:0]  shamt,
  input  logic [2:0]  op,
  output logic        out_valid,
  output logic [15:0] o
);

  localparam logic [2:0] OP_SLL = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd1;
  localparam logic [2:0] OP_SRA = 3'd2;
  localparam logic [2:0] OP_ROL = 3'd3;
  localparam logic [2:0] OP_ROR = 3'd4;

  // One fixed-distance mux stage. The distance k is a constant at every call
  // site, so each output bit reduces to a 2:1 (or 3:1) mux on fixed wires.
  // The SRA fill uses bit 15 of the stage input. Every earlier SRA stage
  // copies the operand's sign into bit 15, so this is always the original i[15].
  function automatic logic [15:0] stage_shift(input logic [15:0] x,
                                              input logic [2:0]  sel,
                                              input int          k);
    logic [15:0] r;
    int          src;
    r = x;
    for (int b = 0; b < 16; b++) begin
      case (sel)
        OP_SLL: begin
          src  = b - k;
          r[b] = (src >= 0) ? x[src[3:0]] : 1'b0;
        end
        OP_SRL: begin
          src  = b + k;
          r[b] = (src < 16) ? x[src[3:0]] : 1'b0;
        end
        OP_SRA: begin
          src  = b + k;
          r[b] = (src < 16) ? x[src[3:0]] : x[15];
        end
        OP_ROL: begin
          src  = (b + 16 - k) % 16;
          r[b] = x[src[3:0]];
        end
        OP_ROR: begin
          src  = (b + k) % 16;
          r[b] = x[src[3:0]];
        end
        default: r[b] = x[b];
      endcase
    end
    return r;
  endfunction

  logic [15:0] stage1;
  logic [15:0] stage2;
  logic [15:0] stage4;
  logic [15:0] stage8;

  // Combinational core: each shamt bit enables one stage of its own weight.
  always_comb begin
    stage1 = shamt[0] ? stage_shift(i,      op, 1) : i;
    stage2 = shamt[1] ? stage_shift(stage1, op, 2) : stage1;
    stage4 = shamt[2] ? stage_shift(stage2, op, 4) : stage2;
    stage8 = shamt[3] ? stage_shift(stage4, op, 8) : stage4;
  end

  // Output register: capture on valid, hold the word otherwise; reset clears both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o         <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o <= stage8;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and randomized checks of the registered barrel shifter.
module tb_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] i;
  logic [3:0]  shamt;
  logic [2:0]  op;
  logic        out_valid;
  logic [15:0] o;

  int errors = 0;
  int checks = 0;

  barrel_shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .i        (i),
    .shamt    (shamt),
    .op       (op),
    .out_valid(out_valid),
    .o        (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one set of inputs, let one rising edge sample them, settle for #1.
  task automatic step(input logic rn, input logic v, input logic [15:0] d,
                      input logic [3:0] n, input logic [2:0] sel);
    rst_n    = rn;
    in_valid = v;
    i        = d;
    shamt    = n;
    op       = sel;
    @(posedge clk);
    #1;
  endtask

  // Reference written with plain shift operators on a 32-bit copy.
  function automatic logic [15:0] ref_model(input logic [15:0] d, input logic [3:0] n,
                                            input logic [2:0] sel);
    logic [31:0] w;
    logic [31:0] sext;
    w    = {16'h0000, d};
    sext = {{16{d[15]}}, d};
    case (sel)
      3'd0:    return 16'(w << n);
      3'd1:    return 16'(w >> n);
      3'd2:    return 16'(sext >> n);
      3'd3:    return 16'((w << n) | (w >> (16 - 32'(n))));
      3'd4:    return 16'((w >> n) | (w << (16 - 32'(n))));
      default: return d;
    endcase
  endfunction

  logic [15:0] exp_seq [5];
  logic [15:0] exp_o;
  logic        exp_v;

  initial begin
    exp_seq[0] = 16'hAF34;
    exp_seq[1] = 16'h2AF3;
    exp_seq[2] = 16'hEAF3;
    exp_seq[3] = 16'hAF36;
    exp_seq[4] = 16'h6AF3;

    rst_n = 1'b0; in_valid = 1'b0; i = '0; shamt = '0; op = '0;

    // Reset dominates a valid input.
    step(1'b0, 1'b1, 16'hFFFF, 4'd0, 3'd0);
    step(1'b0, 1'b1, 16'hFFFF, 4'd0, 3'd0);
    check_eq("reset_o", o, 16'h0000);
    check_eq("reset_valid", {15'd0, out_valid}, 16'd0);
    step(1'b1, 1'b0, 16'hFFFF, 4'd0, 3'd0);
    check_eq("release_valid", {15'd0, out_valid}, 16'd0);
    check_eq("release_o", o, 16'h0000);

    // All five operations on 0xABCD by 2, back to back.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 16'hABCD, 4'd2, 3'(k));
      check_eq($sformatf("abcd_op%0d", k), o, exp_seq[k]);
      check_eq($sformatf("abcd_valid%0d", k), {15'd0, out_valid}, 16'd1);
    end

    step(1'b1, 1'b1, 16'd32, 4'd3, 3'd3);
    check_eq("rol_32_3", o, 16'h0100);
    step(1'b1, 1'b1, 16'h0000, 4'd0, 3'd0);
    check_eq("zero_in", o, 16'h0000);

    // Maximum shift amount.
    step(1'b1, 1'b1, 16'h0001, 4'd15, 3'd3);
    check_eq("rol15", o, 16'h8000);
    step(1'b1, 1'b1, 16'h8000, 4'd15, 3'd2);
    check_eq("sra15", o, 16'hFFFF);
    step(1'b1, 1'b1, 16'h8000, 4'd15, 3'd1);
    check_eq("srl15", o, 16'h0001);
    step(1'b1, 1'b1, 16'h0003, 4'd15, 3'd0);
    check_eq("sll15", o, 16'h8000);
    step(1'b1, 1'b1, 16'h7FFF, 4'd15, 3'd2);
    check_eq("sra15_pos", o, 16'h0000);
    step(1'b1, 1'b1, 16'h0001, 4'd15, 3'd4);
    check_eq("ror15", o, 16'h0002);

    // Zero shift is identity for every opcode.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 16'h1234, 4'd0, 3'(k));
      check_eq($sformatf("shamt0_op%0d", k), o, 16'h1234);
    end

    // Reserved opcodes pass through, then hold when valid drops.
    for (int k = 5; k < 8; k++) begin
      step(1'b1, 1'b1, 16'h5A5A, 4'd4, 3'(k));
      check_eq($sformatf("reserved_op%0d", k), o, 16'h5A5A);
    end
    step(1'b1, 1'b0, 16'h1111, 4'd1, 3'd0);
    check_eq("hold_o", o, 16'h5A5A);
    check_eq("hold_valid", {15'd0, out_valid}, 16'd0);
    step(1'b1, 1'b0, 16'h2222, 4'd3, 3'd1);
    check_eq("hold_o2", o, 16'h5A5A);

    // Reset mid-stream discards the in-flight word; first valid after release
    // reports one cycle later.
    step(1'b1, 1'b1, 16'h00F0, 4'd4, 3'd0);
    check_eq("pre_reset_o", o, 16'h0F00);
    step(1'b0, 1'b1, 16'hFFFF, 4'd1, 3'd0);
    check_eq("mid_reset_o", o, 16'h0000);
    check_eq("mid_reset_valid", {15'd0, out_valid}, 16'd0);
    step(1'b1, 1'b1, 16'h0001, 4'd1, 3'd0);
    check_eq("post_reset_o", o, 16'h0002);
    check_eq("post_reset_valid", {15'd0, out_valid}, 16'd1);

    // Randomized run against the reference model.
    exp_o = o;
    exp_v = out_valid;
    for (int n = 0; n < 1000; n++) begin
      logic        rv;
      logic [15:0] rd;
      logic [3:0]  rn;
      logic [2:0]  rs;
      rv = 1'($urandom_range(0, 1));
      rd = 16'($urandom);
      rn = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      step(1'b1, rv, rd, rn, rs);
      exp_v = rv;
      if (rv) exp_o = ref_model(rd, rn, rs);
      check_eq($sformatf("rand_o_%0d", n), o, exp_o);
      check_eq($sformatf("rand_valid_%0d", n), {15'd0, out_valid}, {15'd0, exp_v});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- 16-bit registered barrel shifter/rotator: one data word, a 4-bit shift amount and a 3-bit opcode in; the shifted/rotated word out.
- Supports logical left, logical right and arithmetic right shifts, plus left and right rotates.
- Used as a shift unit in the datapath.
- Single clock domain; one-cycle latency; one result accepted per cycle.

Parameters:
- None. Data width is fixed at 16 and shift-amount width at 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  qualifies i/shamt/op this cycle
- i  input  16  operand
- shamt  input  4  shift amount, 0..15
- op  input  3  operation select
- out_valid  output  1  o holds a new result this cycle
- o  output  16  registered result

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - rst_n=0 at an edge forces o=16'h0000 and out_valid=0, regardless of in_valid.
- Latency and handshake:
  - Edge with rst_n=1 and in_valid=1: o <= f(i, shamt, op) and out_valid <= 1.
  - Edge with rst_n=1 and in_valid=0: o holds its previous value and out_valid <= 0.
  - Result appears exactly one cycle after the inputs are sampled.
  - Back-to-back valid inputs give back-to-back results; there is no stall or backpressure.
- Operations (n = shamt, unsigned):
  - op=0, SLL: (i << n), truncated to 16 bits, zero fill.
  - op=1, SRL: i >> n, zero fill.
  - op=2, SRA: i >> n, filled with i[15].
  - op=3, ROL: bits leaving bit 15 re-enter at bit 0.
  - op=4, ROR: bits leaving bit 0 re-enter at bit 15.
  - op=5..7: reserved; the result is i unchanged (pass-through).
- Boundary rules:
  - n=0 gives o=i for every op.
  - n=15 is the maximum shift. SLL keeps only i[0], placed in bit 15. SRL keeps only i[15], placed in bit 0. SRA gives all copies of i[15].
- Implementation:
  - Combinational core built as log2 staged muxing: 4 stages of 1, 2, 4 and 8 bit positions, with no variable-shift operator chains required.
  - Output register after the core.
  - No X propagation from a reserved op; every op value yields a defined result.
- Reset applied mid-stream discards the in-flight result. The first valid input after reset release produces out_valid one cycle later.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, i=16'hFFFF -> o=16'h0000, out_valid=0. Release reset with in_valid=0 -> out_valid stays 0.
- i=16'hABCD, shamt=2, op=0..4 applied on consecutive cycles with in_valid=1 -> o equals 16'hAF34, 16'h2AF3, 16'hEAF3, 16'hAF36, 16'h6AF3 respectively, each one cycle later, with out_valid=1 throughout.
- i=16'd32, shamt=3, op=3 -> o=16'h0100. Then i=16'h0000, shamt=0, op=0 -> o=16'h0000.
- Extremes:
  - shamt=15: op=3 with i=16'h0001 -> 16'h8000; op=2 with i=16'h8000 -> 16'hFFFF; op=1 with i=16'h8000 -> 16'h0001; op=0 with i=16'h0003 -> 16'h8000.
  - shamt=0 for each op with i=16'h1234 -> 16'h1234.
- Reserved ops and hold:
  - op=5, 6 or 7 with i=16'h5A5A, shamt=4 -> 16'h5A5A.
  - Then deassert in_valid -> o holds 16'h5A5A and out_valid=0.
- Randomized run: 1000 random i/shamt/op values with random in_valid -> every result matches a reference model of the above rules, one cycle delayed.
